// File: rtl/cosim_trace_queue.sv
// Purpose: compacts up to COMMIT_WIDTH commit records plus one trap per cycle into an ordered queue for the cosim checker.
// Latency: a record pushed in cycle t is at the head no earlier than cycle t+1; head fields are combinational from storage.
// Backpressure: in_ready needs room for a full cycle (COMMIT_WIDTH+1); out_ready stalls the head; an offer while not ready sets sticky overflow.
// Optional feature: define COSIM_TRACE_SEQ_EN to add out_seq, a per-record enqueue sequence number.
module cosim_trace_queue #(
    parameter int COMMIT_WIDTH = 2,
    parameter int XLEN         = 64,
    parameter int DEPTH        = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         in_ready,
    input  logic [COMMIT_WIDTH-1:0]      in_valid,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
    input  logic [32*COMMIT_WIDTH-1:0]   in_inst,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
    input  logic [COMMIT_WIDTH-1:0]      in_check,
    input  logic                         in_int_xcpt,
    input  logic [XLEN-1:0]              in_cause,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_is_trap,
    output logic [XLEN-1:0]              out_pc,
    output logic [XLEN-1:0]              out_wdata,
    output logic [XLEN-1:0]              out_mstatus,
    output logic [31:0]                  out_inst,
    output logic                         out_check,
    output logic [XLEN-1:0]              out_cause,
    output logic                         overflow
`ifdef COSIM_TRACE_SEQ_EN
    ,
    output logic [31:0]                  out_seq
`endif
);

    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = $clog2(DEPTH + 1);
    localparam int READY_MAX = DEPTH - COMMIT_WIDTH - 1;

    // Queue pointers and occupancy.
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    // Per-entry storage.
    logic            mem_trap    [DEPTH];
    logic [XLEN-1:0] mem_pc      [DEPTH];
    logic [XLEN-1:0] mem_wdata   [DEPTH];
    logic [XLEN-1:0] mem_mstatus [DEPTH];
    logic [31:0]     mem_inst    [DEPTH];
    logic            mem_check   [DEPTH];
    logic [XLEN-1:0] mem_cause   [DEPTH];
`ifdef COSIM_TRACE_SEQ_EN
    logic [31:0]     mem_seq     [DEPTH];
    logic [31:0]     seq_cnt;
`endif

    // Compaction: each valid slot lands at tail plus the number of valid lower slots.
    // Offsets never exceed COMMIT_WIDTH+1, which is below DEPTH, so AW bits suffice.
    logic [AW-1:0] slot_ofs [COMMIT_WIDTH];
    logic [AW-1:0] slot_idx [COMMIT_WIDTH];
    logic [AW-1:0] n_commit;
    logic [AW-1:0] n_push;
    logic [AW-1:0] trap_idx;
    logic          offered;
    logic          push;
    logic          pop;

    // Per-slot write offsets and total number of entries offered this cycle.
    always_comb begin
        n_commit = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            slot_ofs[i] = n_commit;
            slot_idx[i] = tail + n_commit;
            if (in_valid[i]) begin
                n_commit = n_commit + AW'(1);
            end
        end
        n_push   = n_commit + AW'(in_int_xcpt);
        trap_idx = tail + n_commit;
    end

    assign in_ready  = (count <= CW'(READY_MAX));
    assign out_valid = (count != '0);
    assign offered   = (|in_valid) | in_int_xcpt;
    assign push      = offered & in_ready;
    assign pop       = out_valid & out_ready;

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                head <= head + AW'(1);
            end
            if (push) begin
                tail <= tail + n_push;
            end
            count <= count + (push ? CW'(n_push) : CW'(0)) - CW'(pop);
            if (offered && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // Entry writes: commits in ascending slot order, then the trap behind them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_trap[j]    <= 1'b0;
                mem_pc[j]      <= '0;
                mem_wdata[j]   <= '0;
                mem_mstatus[j] <= '0;
                mem_inst[j]    <= '0;
                mem_check[j]   <= 1'b0;
                mem_cause[j]   <= '0;
            end
        end else if (push) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (in_valid[i]) begin
                    mem_trap[slot_idx[i]]    <= 1'b0;
                    mem_pc[slot_idx[i]]      <= in_pc[i*XLEN +: XLEN];
                    mem_wdata[slot_idx[i]]   <= in_wdata[i*XLEN +: XLEN];
                    mem_mstatus[slot_idx[i]] <= in_mstatus[i*XLEN +: XLEN];
                    mem_inst[slot_idx[i]]    <= in_inst[i*32 +: 32];
                    mem_check[slot_idx[i]]   <= in_check[i];
                    mem_cause[slot_idx[i]]   <= '0;
                end
            end
            if (in_int_xcpt) begin
                mem_trap[trap_idx]    <= 1'b1;
                mem_pc[trap_idx]      <= '0;
                mem_wdata[trap_idx]   <= '0;
                mem_mstatus[trap_idx] <= '0;
                mem_inst[trap_idx]    <= '0;
                mem_check[trap_idx]   <= 1'b0;
                mem_cause[trap_idx]   <= in_cause;
            end
        end
    end

`ifdef COSIM_TRACE_SEQ_EN
    // Sequence numbers follow enqueue order and wrap naturally at 2^32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seq_cnt <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                mem_seq[j] <= '0;
            end
        end else if (push) begin
            seq_cnt <= seq_cnt + 32'(n_push);
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (in_valid[i]) begin
                    mem_seq[slot_idx[i]] <= seq_cnt + 32'(slot_ofs[i]);
                end
            end
            if (in_int_xcpt) begin
                mem_seq[trap_idx] <= seq_cnt + 32'(n_commit);
            end
        end
    end
`endif

    // Head fields, forced to zero whenever the queue is empty.
    always_comb begin
        out_is_trap = 1'b0;
        out_pc      = '0;
        out_wdata   = '0;
        out_mstatus = '0;
        out_inst    = '0;
        out_check   = 1'b0;
        out_cause   = '0;
`ifdef COSIM_TRACE_SEQ_EN
        out_seq     = '0;
`endif
        if (out_valid) begin
            out_is_trap = mem_trap[head];
            out_pc      = mem_pc[head];
            out_wdata   = mem_wdata[head];
            out_mstatus = mem_mstatus[head];
            out_inst    = mem_inst[head];
            out_check   = mem_check[head];
            out_cause   = mem_cause[head];
`ifdef COSIM_TRACE_SEQ_EN
            out_seq     = mem_seq[head];
`endif
        end
    end

endmodule

// File: tb/tb_cosim_trace_queue.sv
// Purpose: self-checking bench for cosim_trace_queue against a queue-based reference model.
// Latency: model entries become visible at the step after the push, matching one-cycle enqueue latency.
// Backpressure: out_ready and offered pushes are driven per step; the model drops offers when room < COMMIT_WIDTH+1.
module tb_cosim_trace_queue;

    localparam int CWD = 2;
    localparam int XL  = 64;
    localparam int DP  = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [CWD-1:0] in_valid;
    logic [63:0]    pc  [CWD];
    logic [63:0]    wd  [CWD];
    logic [63:0]    ms  [CWD];
    logic [31:0]    ins [CWD];
    logic [CWD-1:0] cen;
    logic           in_int_xcpt;
    logic [63:0]    in_cause;
    logic           out_ready;

    logic [XL*CWD-1:0] in_pc;
    logic [XL*CWD-1:0] in_wdata;
    logic [XL*CWD-1:0] in_mstatus;
    logic [32*CWD-1:0] in_inst;
    assign in_pc      = {pc[1], pc[0]};
    assign in_wdata   = {wd[1], wd[0]};
    assign in_mstatus = {ms[1], ms[0]};
    assign in_inst    = {ins[1], ins[0]};

    logic        in_ready, out_valid, out_is_trap, out_check, overflow;
    logic [63:0] out_pc, out_wdata, out_mstatus, out_cause;
    logic [31:0] out_inst;
`ifdef COSIM_TRACE_SEQ_EN
    logic [31:0] out_seq;
`endif

    cosim_trace_queue #(.COMMIT_WIDTH(CWD), .XLEN(XL), .DEPTH(DP)) dut (
        .clock(clock), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
        .in_pc(in_pc), .in_inst(in_inst), .in_wdata(in_wdata), .in_mstatus(in_mstatus),
        .in_check(cen), .in_int_xcpt(in_int_xcpt), .in_cause(in_cause),
        .out_valid(out_valid), .out_ready(out_ready), .out_is_trap(out_is_trap),
        .out_pc(out_pc), .out_wdata(out_wdata), .out_mstatus(out_mstatus),
        .out_inst(out_inst), .out_check(out_check), .out_cause(out_cause),
        .overflow(overflow)
`ifdef COSIM_TRACE_SEQ_EN
        , .out_seq(out_seq)
`endif
    );

    typedef struct packed {
        logic        trap;
        logic [63:0] pc;
        logic [63:0] wdata;
        logic [63:0] mstatus;
        logic [31:0] inst;
        logic        chk;
        logic [63:0] cause;
        logic [31:0] seq;
    } rec_t;

    rec_t        q[$];
    logic        m_ovf;
    logic [31:0] m_seq;
    int          n_vec;
    int          n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < CWD; i++) begin
            pc[i]  = {$urandom, $urandom};
            wd[i]  = {$urandom, $urandom};
            ms[i]  = {$urandom, $urandom};
            ins[i] = $urandom;
        end
        cen      = 2'($urandom);
        in_cause = {$urandom, $urandom};
    endtask

    task automatic idle();
        rand_data();
        in_valid    = '0;
        in_int_xcpt = 1'b0;
    endtask

    // Compare head against the model, then advance the model by one clock.
    task automatic step();
        logic offered;
        logic rdy;
        rec_t r;
        #1;
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("in_ready", 64'(in_ready), 64'((DP - q.size()) >= CWD + 1));
        check("overflow", 64'(overflow), 64'(m_ovf));
        if (q.size() != 0) begin
            check("is_trap", 64'(out_is_trap), 64'(q[0].trap));
            if (q[0].trap) begin
                check("cause", out_cause, q[0].cause);
            end else begin
                check("pc", out_pc, q[0].pc);
                check("inst", 64'(out_inst), 64'(q[0].inst));
                check("wdata", out_wdata, q[0].wdata);
                check("mstatus", out_mstatus, q[0].mstatus);
                check("check", 64'(out_check), 64'(q[0].chk));
            end
`ifdef COSIM_TRACE_SEQ_EN
            check("seq", 64'(out_seq), 64'(q[0].seq));
`endif
        end
        offered = (|in_valid) | in_int_xcpt;
        rdy     = (DP - q.size()) >= CWD + 1;
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (offered) begin
            if (rdy) begin
                for (int i = 0; i < CWD; i++) begin
                    if (in_valid[i]) begin
                        r = '0;
                        r.pc = pc[i]; r.wdata = wd[i]; r.mstatus = ms[i];
                        r.inst = ins[i]; r.chk = cen[i]; r.seq = m_seq;
                        q.push_back(r);
                        m_seq++;
                    end
                end
                if (in_int_xcpt) begin
                    r = '0;
                    r.trap = 1'b1; r.cause = in_cause; r.seq = m_seq;
                    q.push_back(r);
                    m_seq++;
                end
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        n_vec = 0; n_err = 0; m_ovf = 1'b0; m_seq = '0;
        out_ready = 1'b0;
        idle();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        // Reset state.
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_is_trap", 64'(out_is_trap), 64'(0));
        check("rst_pc", out_pc, 64'(0));
        check("rst_wdata", out_wdata, 64'(0));
        check("rst_mstatus", out_mstatus, 64'(0));
        check("rst_inst", 64'(out_inst), 64'(0));
        check("rst_check", 64'(out_check), 64'(0));
        check("rst_cause", out_cause, 64'(0));
`ifdef COSIM_TRACE_SEQ_EN
        check("rst_seq", 64'(out_seq), 64'(0));
`endif
        @(negedge clock);
        reset = 1'b1;
        step();

        // Wrap: preload 15 (tail ends at 15), drain, then a 2-entry push straddles 15 -> 0.
        out_ready = 1'b0;
        for (int k = 0; k < 13; k++) begin rand_data(); in_valid = 2'b01; step(); end
        rand_data(); in_valid = 2'b11; step();
        out_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin idle(); step(); end
        rand_data(); in_valid = 2'b11; step();
        for (int k = 0; k < 3; k++) begin idle(); step(); end

        // Ordering: two commits then a trap in the same cycle.
        rand_data();
        in_valid = 2'b11; pc[0] = 64'h8000_0000; pc[1] = 64'h8000_0004;
        in_int_xcpt = 1'b1; in_cause = 64'h8000_0000_0000_0007;
        step();
        for (int k = 0; k < 4; k++) begin idle(); step(); end

        // Compaction: only slot 1 valid.
        rand_data(); in_valid = 2'b10; pc[1] = 64'h1000; step();
        for (int k = 0; k < 2; k++) begin idle(); step(); end

        // Backpressure to full threshold, then one rejected offer.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin rand_data(); in_valid = 2'b11; step(); end
        out_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin idle(); step(); end

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            rand_data();
            in_valid    = ($urandom_range(0, 1) == 1) ? 2'($urandom) : 2'b00;
            in_int_xcpt = ($urandom_range(0, 3) == 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset mid-drain with five entries queued.
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin idle(); step(); end
        out_ready = 1'b0;
        rand_data(); in_valid = 2'b11; step();
        rand_data(); in_valid = 2'b11; step();
        rand_data(); in_valid = 2'b01; step();
        out_ready = 1'b1;
        idle();
        #2 reset = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_overflow", 64'(overflow), 64'(0));
        q.delete(); m_ovf = 1'b0; m_seq = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        step();
        rand_data(); in_valid = 2'b11; in_int_xcpt = 1'b1; step();
        for (int k = 0; k < 5; k++) begin idle(); step(); end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
